// File: rtl/lut_neuron_prog.sv
// Runtime-programmable LUT neuron: a truth table is streamed into a shadow bank,
// swapped atomically into the active bank, and served as registered lookups.
module lut_neuron_prog #(
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 1,
  parameter int WORD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 prog_start,
  input  logic                 prog_valid,
  output logic                 prog_ready,
  input  logic [WORD_BITS-1:0] prog_data,
  output logic                 prog_done,
  output logic                 table_loaded,
  input  logic                 in_valid,
  input  logic [IN_BITS-1:0]   in_data,
  output logic                 out_valid,
  output logic [OUT_BITS-1:0]  out_data,
  output logic [1:0]           state_dbg
);

  localparam int ENTRIES  = 1 << IN_BITS;
  localparam int TBL_BITS = ENTRIES * OUT_BITS;
  localparam int NWORDS   = TBL_BITS / WORD_BITS;
  localparam int CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic accept;
  logic commit;

  // Word w of a bank occupies bits [w*WORD_BITS +: WORD_BITS], so the packed
  // entry view below places global entry w*EPW+k at bits [(w*EPW+k)*OUT_BITS +: OUT_BITS].
  logic [NWORDS-1:0][WORD_BITS-1:0] shadow;
  logic [NWORDS-1:0][WORD_BITS-1:0] active;
  logic [ENTRIES-1:0][OUT_BITS-1:0] active_ent;

  assign active_ent = active;
  assign state_dbg  = state;

  // Handshake: a beat transfers on a rising edge where prog_valid && prog_ready
  // are both high; prog_ready depends only on state, never on prog_valid.
  // A prog_start in the same cycle restarts the load and the beat is dropped.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (prog_start) state_nxt = LOAD;
      end
      LOAD: begin
        if (prog_start)                  state_nxt = LOAD;
        else if (accept && cnt == LAST)  state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = prog_start ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prog_ready = (state == LOAD);
    accept     = (state == LOAD) && prog_valid && !prog_start;
    commit     = (state == COMMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (prog_start) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (accept) begin
      shadow[cnt] <= prog_data;
    end
  end

  // The copy lands on the edge that ends COMMIT, so a lookup sampled on that
  // same edge still reads the old table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active       <= '0;
      prog_done    <= 1'b0;
      table_loaded <= 1'b0;
    end else begin
      if (commit) active <= shadow;
      prog_done    <= commit;
      table_loaded <= table_loaded | commit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_data  <= in_valid ? active_ent[in_data] : '0;
    end
  end

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Bench for lut_neuron_prog: programs tables over the stream port and checks
// lookups through an expected-value queue drained by an output monitor.
module tb_lut_neuron_prog;

  localparam int IN_BITS   = 8;
  localparam int OUT_BITS  = 1;
  localparam int WORD_BITS = 8;
  localparam int NWORDS    = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 prog_start;
  logic                 prog_valid;
  logic                 prog_ready;
  logic [WORD_BITS-1:0] prog_data;
  logic                 prog_done;
  logic                 table_loaded;
  logic                 in_valid;
  logic [IN_BITS-1:0]   in_data;
  logic                 out_valid;
  logic [OUT_BITS-1:0]  out_data;
  logic [1:0]           state_dbg;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [OUT_BITS-1:0]  exp_q[$];
  logic [OUT_BITS-1:0]  exp_v;
  logic [WORD_BITS-1:0] load_words[NWORDS];

  lut_neuron_prog #(
    .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .WORD_BITS(WORD_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_start(prog_start), .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_data(prog_data), .prog_done(prog_done), .table_loaded(table_loaded),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (prog_done) done_cnt++;
      total++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL lookup_unexpected: out_valid=1 out_data=%0h, no lookup outstanding", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_data !== exp_v) begin
            bad++;
            $display("FAIL lookup_data: got %0h want %0h at %0t", out_data, exp_v, $time);
          end
        end
      end else if (out_data !== '0) begin
        bad++;
        $display("FAIL idle_data: out_data=%0h want 0 while out_valid=0", out_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic look(input logic [7:0] a, input logic [OUT_BITS-1:0] e);
    in_valid = 1'b1;
    in_data  = a;
    exp_q.push_back(e);
  endtask

  task automatic look_off();
    in_valid = 1'b0;
  endtask

  task automatic fill(input logic [WORD_BITS-1:0] w);
    for (int i = 0; i < NWORDS; i++) load_words[i] = w;
  endtask

  task automatic settle();
    repeat (2) tick();
  endtask

  // Streams nbeats words from load_words; returns right after the last accept edge.
  task automatic stream_load(input int nbeats, input bit gaps, input bit do_start);
    int acc = 0;
    int cyc = 0;
    bit take;
    if (do_start) begin
      prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
    end
    while (acc < nbeats && cyc < 400) begin
      prog_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
      prog_data  = load_words[acc];
      take = prog_valid && prog_ready;
      tick();
      if (take) acc++;
      cyc++;
    end
    prog_valid = 1'b0;
    if (acc < nbeats) begin
      total++;
      bad++;
      $display("FAIL stream_timeout: accepted %0d want %0d", acc, nbeats);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; prog_start = 1'b0; prog_valid = 1'b0; prog_data = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (prog_ready !== 1'b0)   begin bad++; $display("FAIL reset_ready: got %b want 0", prog_ready); end
    total++; if (prog_done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b want 0", prog_done); end
    total++; if (table_loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded: got %b want 0", table_loaded); end
    total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== '0)       begin bad++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    total++; if (state_dbg !== 2'd0)    begin bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lookup_before_load();
    look(8'h00, 1'b0); tick();
    look(8'h7F, 1'b0); tick();
    look(8'hFF, 1'b0); tick();
    look_off(); settle();
    total++; if (table_loaded !== 1'b0) begin bad++; $display("FAIL preload_loaded: got %b want 0", table_loaded); end
  endtask

  task automatic test_full_load();
    int d0 = done_cnt;
    fill(8'hA5);
    stream_load(NWORDS, 1'b0, 1'b1);
    total++; if (prog_ready !== 1'b0) begin bad++; $display("FAIL full_ready_drop: got %b want 0", prog_ready); end
    total++; if (prog_done !== 1'b0)  begin bad++; $display("FAIL full_done_early: got %b want 0", prog_done); end
    tick();
    total++; if (prog_done !== 1'b1)    begin bad++; $display("FAIL full_done_pulse: got %b want 1", prog_done); end
    total++; if (table_loaded !== 1'b1) begin bad++; $display("FAIL full_loaded: got %b want 1", table_loaded); end
    tick();
    total++; if (prog_done !== 1'b0) begin bad++; $display("FAIL full_done_width: got %b want 0", prog_done); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL full_done_count: got %0d want 1", done_cnt - d0); end
    look(8'h00, 1'b1); tick();
    look(8'h01, 1'b0); tick();
    look(8'h02, 1'b1); tick();
    look(8'h07, 1'b1); tick();
    look(8'h85, 1'b1); tick();
    look(8'h46, 1'b0); tick();
    look_off(); settle();
  endtask

  task automatic test_random_load();
    int d0 = done_cnt;
    logic [7:0] a;
    for (int i = 0; i < NWORDS; i++) load_words[i] = 8'($urandom_range(0, 255));
    stream_load(NWORDS, 1'b0, 1'b1);
    settle();
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rand_done_count: got %0d want 1", done_cnt - d0); end
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      look(a, load_words[a[7:3]][a[2:0]]);
      tick();
    end
    look_off(); settle();
  endtask

  task automatic test_gaps();
    int d0 = done_cnt;
    fill(8'hA5);
    stream_load(NWORDS, 1'b1, 1'b1);
    total++; if (prog_done !== 1'b0) begin bad++; $display("FAIL gaps_done_early: got %b want 0", prog_done); end
    total++; if (done_cnt != d0)     begin bad++; $display("FAIL gaps_done_before_last: got %0d want 0", done_cnt - d0); end
    settle();
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL gaps_done_count: got %0d want 1", done_cnt - d0); end
    look(8'h00, 1'b1); tick();
    look(8'h01, 1'b0); tick();
    look(8'h02, 1'b1); tick();
    look(8'h07, 1'b1); tick();
    look(8'hF3, 1'b0); tick();
    look_off(); settle();
  endtask

  task automatic test_atomic_swap();
    int d0;
    fill(8'hFF);
    stream_load(NWORDS, 1'b0, 1'b1);
    settle();
    fill(8'h00);
    d0 = done_cnt;
    prog_start = 1'b1;
    look(8'h10, 1'b1);
    tick();
    prog_start = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      prog_valid = 1'b1;
      prog_data  = load_words[i];
      look(8'h10, 1'b1);
      tick();
    end
    prog_valid = 1'b0;
    total++; if (state_dbg !== 2'd2) begin bad++; $display("FAIL swap_commit_state: got %0d want 2", state_dbg); end
    look(8'h10, 1'b1); tick();
    look(8'h10, 1'b0); tick();
    look(8'h10, 1'b0); tick();
    look_off(); settle();
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL swap_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    int d0;
    fill(8'hFF);
    stream_load(NWORDS, 1'b0, 1'b1);
    settle();
    d0 = done_cnt;
    stream_load(10, 1'b0, 1'b1);
    look(8'h33, 1'b1); tick(); look_off();
    prog_start = 1'b1; prog_valid = 1'b1; prog_data = 8'hFF;
    tick();
    prog_start = 1'b0; prog_valid = 1'b0;
    fill(8'h00);
    stream_load(NWORDS, 1'b0, 1'b0);
    settle();
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL abort_done_count: got %0d want 1", done_cnt - d0); end
    look(8'h00, 1'b0); tick();
    look(8'h33, 1'b0); tick();
    look(8'h80, 1'b0); tick();
    look(8'hFF, 1'b0); tick();
    look_off(); settle();
  endtask

  task automatic test_reset_mid_load();
    int d0;
    fill(8'hFF);
    stream_load(NWORDS, 1'b0, 1'b1);
    settle();
    stream_load(20, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    total++; if (table_loaded !== 1'b0) begin bad++; $display("FAIL midrst_loaded: got %b want 0", table_loaded); end
    total++; if (prog_ready !== 1'b0)   begin bad++; $display("FAIL midrst_ready: got %b want 0", prog_ready); end
    total++; if (state_dbg !== 2'd0)    begin bad++; $display("FAIL midrst_state: got %0d want 0", state_dbg); end
    tick();
    rst_n = 1'b1;
    tick();
    look(8'hFF, 1'b0); tick();
    look_off(); settle();
    fill(8'hA5);
    d0 = done_cnt;
    stream_load(NWORDS, 1'b0, 1'b1);
    settle();
    total++; if (done_cnt - d0 != 1)    begin bad++; $display("FAIL midrst_reload_done: got %0d want 1", done_cnt - d0); end
    total++; if (table_loaded !== 1'b1) begin bad++; $display("FAIL midrst_reload_loaded: got %b want 1", table_loaded); end
    look(8'h00, 1'b1); tick();
    look(8'h01, 1'b0); tick();
    look_off(); settle();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_lookup_before_load();
    test_full_load();
    test_random_load();
    test_gaps();
    test_atomic_swap();
    test_abort();
    test_reset_mid_load();
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_lookups: got %0d outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lut_neuron_prog.md
Name: lut_neuron_prog

Overview:
- Runtime-programmable LUT neuron. It is the writer-side counterpart to our generated fixed-ROM neurons.
- Accepts a streamed truth table over a valid/ready programming port and stores it in a shadow bank.
- Atomically swaps the shadow bank into the active bank on completion.
- Serves registered lookups from the active bank. Lets a layer's neuron functions be reloaded in-system without resynthesis.

Parameters:
- IN_BITS, 8, neuron fan-in bits; table has 2^IN_BITS entries.
- OUT_BITS, 1, output bits per entry.
- WORD_BITS, 8, programming word width; must evenly divide 2^IN_BITS*OUT_BITS.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_start  in  1  single-cycle pulse; begin (or restart) a table load.
- prog_valid  in  1  prog_data valid.
- prog_ready  out  1  block accepts prog_data this cycle.
- prog_data  in  WORD_BITS  table word; entry k of word w is bits [k*OUT_BITS +: OUT_BITS], global entry index = w*(WORD_BITS/OUT_BITS)+k.
- prog_done  out  1  one-cycle pulse when new table becomes active.
- table_loaded  out  1  high once any table has been committed since reset.
- in_valid  in  1  lookup request.
- in_data  in  IN_BITS  lookup address, unsigned entry index.
- out_valid  out  1  registered in_valid.
- out_data  out  OUT_BITS  registered table[in_data].

Behaviour:
- Reset (async assert, sync release):
  - FSM returns to IDLE; word counter clears.
  - Both banks clear to all-zero.
  - prog_ready, prog_done, table_loaded, out_valid and out_data all go to 0.
- Derived constants: NWORDS = 2^IN_BITS*OUT_BITS/WORD_BITS (32 at defaults); counter width = clog2(NWORDS).
- FSM states: IDLE, LOAD, COMMIT.
  - IDLE: prog_ready=0. prog_valid is ignored. prog_start -> LOAD with counter=0.
  - LOAD: prog_ready=1.
    - Each cycle with prog_valid&prog_ready writes prog_data to shadow word[counter] and increments counter.
    - The accept at counter=NWORDS-1 -> COMMIT.
    - prog_start while in LOAD aborts: counter=0, stay in LOAD. Shadow contents are don't-care; active bank is untouched. If prog_start and a valid beat coincide, the restart wins and the beat is dropped.
  - COMMIT (one cycle): prog_ready=0. Active bank <= shadow bank (full copy, or bank-select toggle). prog_done=1 and table_loaded<=1 registered from this cycle, visible the next cycle. Then -> IDLE.
    - prog_start in COMMIT is honoured after the swap: next state LOAD, counter=0.
- Lookup pipeline:
  - Latency 1: out_valid/out_data at cycle N+1 reflect in_valid/in_data sampled at edge N.
  - A lookup sampled in the COMMIT cycle reads the old active bank. A lookup sampled the cycle after COMMIT reads the new table. No mixed-table result is ever produced.
  - Lookups are never stalled by programming; there is no backpressure on the lookup path.
  - out_data is 0 while out_valid=0 (registered AND with in_valid).
  - Before the first commit, every lookup returns 0.
- Reset mid-load discards the partial table and the previously committed table; table_loaded returns to 0.
- Storage is distributed RAM style (no block RAM); shadow writes are one word per cycle.

Test Plan:
- Lookup before any load: reset, then in_valid=1 with in_data=0x00,0x7F,0xFF -> out_valid=1 next cycle, out_data=0 each time; table_loaded=0.
- Full load: pulse prog_start, stream 32 words with word w = 8'hA5 every cycle (valid held high) -> prog_ready drops after beat 32, prog_done pulses exactly once. Lookups then give entry i = bit (i%8) of 0xA5: in_data=0x00->1, 0x01->0, 0x02->1, 0x07->1.
- Backpressure/gaps: same load with prog_valid toggling 1,0,1,0 -> identical final table; prog_done after the 32nd accepted beat only.
- Atomic swap: active table = all-ones; load all-zeros while issuing a lookup at in_data=0x10 every cycle -> out_data=1 through the lookup sampled in the COMMIT cycle, 0 from the next sample on.
- Abort: pulse prog_start, send 10 words of 0xFF, pulse prog_start again, send 32 words of 0x00 -> one prog_done only, all lookups 0.
- Reset mid-load: after 20 words, assert rst_n=0 for one cycle -> table_loaded=0, prog_ready=0, lookup 0xFF returns 0. A subsequent full load works normally.
